// File: rtl/detector_borda_multi_if.sv
// Bundles the signals exchanged between the multi-channel edge detector and
// its user. Clock and reset stay outside as plain ports.
//   sinal, modo, limpa : driven by the board/control side
//   pulso, nivel, pendente : driven by the detector
interface detector_borda_multi_if #(
    parameter int N = 4
);
    logic [N-1:0] sinal;     // raw asynchronous inputs, one bit per channel
    logic [1:0]   modo;      // edge select, shared by all channels
    logic [N-1:0] limpa;     // per-channel clear of the sticky flag
    logic [N-1:0] pulso;     // one-cycle pulse per qualified edge
    logic [N-1:0] nivel;     // debounced level
    logic [N-1:0] pendente;  // sticky event flag

    // Control side: drives the inputs and watches the results
    modport master (
        output sinal,
        output modo,
        output limpa,
        input  pulso,
        input  nivel,
        input  pendente
    );

    // Detector side
    modport slave (
        input  sinal,
        input  modo,
        input  limpa,
        output pulso,
        output nivel,
        output pendente
    );
endinterface

// File: rtl/detector_borda_multi.sv
// N-channel debounced edge detector.
// Each channel passes its raw input through a SYNC_STAGES-deep synchroniser,
// then requires the synchronised value to differ from the debounced level for
// DEBOUNCE consecutive cycles before the level is updated. An update whose
// direction is enabled by modo produces a registered one-cycle pulse and sets
// a sticky pending flag, which the control side clears with limpa. A set and
// a clear on the same edge leave the flag set, so no event is lost.
module detector_borda_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    localparam int CW         = $clog2(DEBOUNCE + 1)
) (
    input  logic                  clock,
    input  logic                  reset,   // asynchronous, active-low
    detector_borda_multi_if.slave bus
);

    typedef enum logic [1:0] {
        MODO_NONE = 2'b00,
        MODO_RISE = 2'b01,
        MODO_FALL = 2'b10,
        MODO_BOTH = 2'b11
    } modo_e;

    // Counter value reached on the cycle before a new level is accepted
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    // Synchroniser chain: stage 0 samples the pin, last stage feeds the debouncer
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  sync_s;

    // Debounce and event state
    logic [N-1:0][CW-1:0] cnt_q,      cnt_d;
    logic [N-1:0]         nivel_q,    nivel_d;
    logic [N-1:0]         pulso_q,    pulso_d;
    logic [N-1:0]         pendente_q, pendente_d;

    modo_e modo_sel;
    logic  rise_en;
    logic  fall_en;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign modo_sel = modo_e'(bus.modo);
    assign rise_en  = (modo_sel == MODO_RISE) || (modo_sel == MODO_BOTH);
    assign fall_en  = (modo_sel == MODO_FALL) || (modo_sel == MODO_BOTH);

    // Shift the raw inputs through the synchroniser flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values;
            // with = the chain would collapse into a single stage.
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sinal};
        end
    end

    // Debounce each channel, detect qualified updates, maintain pending flags
    always_comb begin
        // NOTE: every output of this block is given a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        cnt_d   = cnt_q;
        nivel_d = nivel_q;
        pulso_d = '0;

        for (int ch = 0; ch < N; ch++) begin
            if (sync_s[ch] == nivel_q[ch]) begin
                // Input agrees with the accepted level: discard any partial count
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_MAX) begin
                // New level has held long enough: accept it and qualify the edge
                cnt_d[ch]   = '0;
                nivel_d[ch] = sync_s[ch];
                pulso_d[ch] = sync_s[ch] ? rise_en : fall_en;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
        end

        // Setting takes priority over clearing
        pendente_d = pulso_d | (pendente_q & ~bus.limpa);
    end

    // Register debounce counters, levels, pulses and pending flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            nivel_q    <= '0;
            pulso_q    <= '0;
            pendente_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            nivel_q    <= nivel_d;
            pulso_q    <= pulso_d;
            pendente_q <= pendente_d;
        end
    end

    assign bus.pulso    = pulso_q;
    assign bus.nivel    = nivel_q;
    assign bus.pendente = pendente_q;

endmodule

// File: tb/tb_detector_borda_multi.sv
// Directed testbench for detector_borda_multi with default parameters
// (N=4, SYNC_STAGES=2, DEBOUNCE=4). Inputs change 1 time unit after a rising
// edge, so a value written after edge e is first sampled at edge e+1 and a
// qualified pulse appears after the 6th following edge.
module tb_detector_borda_multi;

    localparam int N = 4;

    logic clock;
    logic reset;

    int checks;
    int errors;

    // Results of pulse_run
    int pcount;
    int pfirst;
    int psecond;
    int nivel_seen;

    detector_borda_multi_if #(.N(N)) bus ();

    detector_borda_multi #(
        .N           (N),
        .SYNC_STAGES (2),
        .DEBOUNCE    (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog: the directed sequence is far shorter than this
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Hold sinal[ch] high for high_len edges, then low until total edges have
    // passed; record pulse count, the edge indices of the first two pulses and
    // whether the debounced level ever went high.
    task automatic pulse_run(input int ch, input int high_len, input int total);
        pcount     = 0;
        pfirst     = 0;
        psecond    = 0;
        nivel_seen = 0;
        bus.sinal[ch] = 1'b1;
        for (int i = 1; i <= total; i++) begin
            tick();
            if (i == high_len) bus.sinal[ch] = 1'b0;
            if (bus.pulso[ch]) begin
                pcount++;
                if (pcount == 1) pfirst = i;
                else if (pcount == 2) psecond = i;
            end
            if (bus.nivel[ch]) nivel_seen = 1;
        end
    endtask

    task automatic clear_all();
        bus.limpa = '1;
        tick();
        bus.limpa = '0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.sinal = '0;
        bus.modo  = 2'b01;
        bus.limpa = '0;

        // 1. Reset held while inputs toggle: everything stays 0
        for (int i = 0; i < 6; i++) begin
            bus.sinal = (i % 2 == 0) ? 4'hF : 4'h0;
            tick();
            check("reset_hold", {bus.pulso, bus.nivel, bus.pendente}, 12'h000);
        end
        bus.sinal = '0;
        tick();
        reset = 1'b1;
        repeat (8) tick();
        check("idle_after_release", {bus.pulso, bus.nivel, bus.pendente}, 12'h000);

        // 2. Rise on channel 0, held 10 cycles
        bus.modo     = 2'b01;
        bus.sinal[0] = 1'b1;
        repeat (5) tick();
        check("ch0_before_latency", {bus.pulso, bus.nivel}, 8'h00);
        tick();
        check("ch0_pulse", bus.pulso, 4'h1);
        check("ch0_nivel", bus.nivel, 4'h1);
        check("ch0_pend_set", bus.pendente, 4'h1);
        tick();
        check("ch0_pulse_one_cycle", bus.pulso, 4'h0);
        repeat (3) tick();
        check("ch0_pend_sticky", {bus.pulso, bus.pendente}, 8'h01);
        bus.limpa[0] = 1'b1;
        tick();
        bus.limpa[0] = 1'b0;
        check("ch0_pend_cleared", bus.pendente, 4'h0);
        check("ch0_nivel_held", bus.nivel, 4'h1);
        bus.sinal[0] = 1'b0;
        repeat (6) tick();
        check("ch0_fall_no_pulse_rise_mode", {bus.pulso, bus.nivel, bus.pendente}, 12'h000);

        // 3. Glitch rejection on channel 1, then a valid 5-cycle high
        pulse_run(1, 3, 12);
        check("ch1_glitch_pulses", pcount, 0);
        check("ch1_glitch_nivel", nivel_seen, 0);
        pulse_run(1, 5, 14);
        check("ch1_valid_pulses", pcount, 1);
        check("ch1_valid_edge", pfirst, 6);
        check("ch1_pend", bus.pendente, 4'h2);
        check("ch1_nivel_back_low", bus.nivel, 4'h0);
        clear_all();

        // 4. Edge select on channel 2: both, fall only, none
        bus.modo = 2'b11;
        pulse_run(2, 8, 20);
        check("ch2_both_count", pcount, 2);
        check("ch2_both_rise_edge", pfirst, 6);
        check("ch2_both_fall_edge", psecond, 14);
        clear_all();
        bus.modo = 2'b10;
        pulse_run(2, 8, 20);
        check("ch2_fall_count", pcount, 1);
        check("ch2_fall_edge", pfirst, 14);
        check("ch2_fall_pend", bus.pendente, 4'h4);
        clear_all();
        bus.modo = 2'b00;
        pulse_run(2, 8, 20);
        check("ch2_none_count", pcount, 0);
        check("ch2_none_pend", bus.pendente, 4'h0);
        bus.modo = 2'b11;
        repeat (3) tick();
        check("modo_change_no_pulse", {bus.pulso, bus.pendente}, 8'h00);

        // 5. All channels rise together, clear of channel 3 on the set edge
        bus.modo  = 2'b01;
        bus.sinal = 4'hF;
        repeat (5) tick();
        check("all_before_latency", bus.pulso, 4'h0);
        bus.limpa = 4'b1000;
        tick();
        bus.limpa = '0;
        check("all_pulse", bus.pulso, 4'hF);
        check("all_pend_set_wins", bus.pendente, 4'hF);
        tick();
        check("all_pulse_one_cycle", bus.pulso, 4'h0);
        check("all_pend_sticky", bus.pendente, 4'hF);

        // 6. Reset in the middle of a debounce
        bus.sinal = 4'b1000;
        repeat (8) tick();
        check("pre_reset_nivel", bus.nivel, 4'h8);
        bus.sinal = 4'b1001;
        repeat (4) tick();
        check("mid_debounce_state", {bus.pulso, bus.nivel, bus.pendente}, 12'h08F);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_clears", {bus.pulso, bus.nivel, bus.pendente}, 12'h000);
        tick();
        tick();
        check("reset_no_pulse", {bus.pulso, bus.nivel, bus.pendente}, 12'h000);
        reset = 1'b1;
        repeat (5) tick();
        check("powerup_before_latency", {bus.pulso, bus.nivel}, 8'h00);
        tick();
        check("powerup_pulse", bus.pulso, 4'h9);
        check("powerup_nivel_pend", {bus.nivel, bus.pendente}, 8'h99);
        tick();
        check("powerup_pulse_one_cycle", bus.pulso, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
